shop_item_table: RTL
====================

// Module: shop_item_table
// PURPOSE
//   Parametrised item database for the shop engine: holds up to MAX_ITEMS items (name, owner, stock).
//   Executes ADD / DELETE / BUY / QUERY requests issued by the command FSM over a valid/ready handshake.
//   Lookup is a sequential one-slot-per-cycle scan.
//   Returns one status code per request; the command FSM maps the code to its out-string.
// PARAMETERS
//   NAME_CHARS  7               ASCII chars per item name
//   NAME_BITS   NAME_CHARS*8    item name width
//   STOCK_BITS  8               stock / quantity width (unsigned)
//   MAX_ITEMS   8               table depth, >=2
//   USER_BITS   4               user number width (matches user table index)
// PORTS
//   i_clk      in   1           clock
//   i_reset    in   1           synchronous, active-high reset
//   i_valid    in   1           request valid
//   o_ready    out  1           block idle, can accept request
//   i_op       in   2           00 ADD, 01 DEL, 10 BUY, 11 QUERY
//   i_user     in   USER_BITS   requesting user number
//   i_is_admin in   1           requester has admin perms
//   i_name     in   NAME_BITS   item name (ASCII, right-justified)
//   i_qty      in   STOCK_BITS  ADD: initial stock; BUY: quantity; else ignored
//   o_done     out  1           1-cycle pulse, result valid
//   o_status   out  3           0 OK, 1 FULL, 2 EXISTS, 3 UNKNOWN, 4 NOT_OWNER, 5 NO_STOCK, 6 BAD_QTY
//   o_stock    out  STOCK_BITS  item stock after op (0 when status != OK)
//   o_count    out  $clog2(MAX_ITEMS+1)  number of valid items
// BEHAVIOUR
//   Reset (sync, i_clk edge with i_reset=1):
//   - all slots invalid; state IDLE
//   - o_done=0, o_status=0, o_stock=0, o_count=0
//   - i_valid ignored while i_reset=1
//   Reset mid-operation aborts the request; no o_done is issued.
//   FSM IDLE -> SCAN -> EXEC -> IDLE. o_ready = (state==IDLE).
//   IDLE: on i_valid&o_ready latch op/user/admin/name/qty; idx=0; ->SCAN. Inputs are free to change after accept.
//   SCAN: one slot per cycle, idx 0..MAX_ITEMS-1.
//   - record lowest free slot and matching valid slot (names unique, so at most one match)
//   - after idx==MAX_ITEMS-1 -> EXEC; no early exit, so latency is fixed
//   EXEC: update table and outputs; o_done=1 for this cycle only; ->IDLE.
//   Latency: accept edge N -> o_done high in the cycle after edge N+MAX_ITEMS+1.
//   Next accept is possible one cycle later, so throughput is 1 request per MAX_ITEMS+2 cycles.
//   ADD:   match -> EXISTS; else no free slot -> FULL; else write lowest free slot (owner=i_user, stock=i_qty), OK.
//          EXISTS takes priority over FULL. i_qty=0 is allowed.
//   DEL:   no match -> UNKNOWN; owner!=i_user and !i_is_admin -> NOT_OWNER; else invalidate slot, OK, o_stock=0.
//   BUY:   i_qty==0 -> BAD_QTY; else no match -> UNKNOWN; else stock<i_qty -> NO_STOCK (no partial buy).
//          Otherwise stock -= i_qty, OK, o_stock = new stock.
//          Buying your own item is permitted. Stock never wraps.
//   QUERY: no match -> UNKNOWN; else OK, o_stock = stock; table unchanged.
//   Status outputs: o_status/o_stock hold their value until the next EXEC.
//   o_count: updated in EXEC (+1 on ADD OK, -1 on DEL OK).
//   Freed slots are reused lowest-first.
// TESTING (MAX_ITEMS=4, STOCK_BITS=8 unless noted)
//   Reset, then QUERY "Lamp" -> o_done exactly 6 cycles after accept; status UNKNOWN; o_count 0.
//   ADD "Lamp" qty 5 by user 2; ADD "Lamp" again -> OK then EXISTS; o_count 1.
//   Fill 4 items; ADD 5th -> FULL; DEL slot 1 item, ADD new -> lands in slot 1.
//   BUY "Lamp" qty 3 -> OK, o_stock 2; BUY qty 3 -> NO_STOCK, stock stays 2.
//   BUY qty 0 -> BAD_QTY.
//   DEL "Lamp" by user 3 non-admin -> NOT_OWNER; by user 3 with i_is_admin -> OK, o_count decrements.
//   Assert i_reset mid-SCAN -> no o_done; o_ready=1 after reset; o_count 0; QUERY of a prior item -> UNKNOWN.

Source files
------------

// File: rtl/shop_item_table_if.sv
// Request/response bundle between the command FSM and the item table.
// Pure wiring; no storage, so it adds no latency.
// Backpressure: o_ready low holds off i_valid; o_done is a single-cycle pulse with no ready.
interface shop_item_table_if #(
    parameter int NAME_BITS  = 56,
    parameter int STOCK_BITS = 8,
    parameter int USER_BITS  = 4,
    parameter int CNT_BITS   = 4
);
    logic                  i_valid;
    logic                  o_ready;
    logic [1:0]            i_op;
    logic [USER_BITS-1:0]  i_user;
    logic                  i_is_admin;
    logic [NAME_BITS-1:0]  i_name;
    logic [STOCK_BITS-1:0] i_qty;
    logic                  o_done;
    logic [2:0]            o_status;
    logic [STOCK_BITS-1:0] o_stock;
    logic [CNT_BITS-1:0]   o_count;

    // Command FSM side
    modport master (
        output i_valid, i_op, i_user, i_is_admin, i_name, i_qty,
        input  o_ready, o_done, o_status, o_stock, o_count
    );

    // Item table side
    modport slave (
        input  i_valid, i_op, i_user, i_is_admin, i_name, i_qty,
        output o_ready, o_done, o_status, o_stock, o_count
    );
endinterface

// File: rtl/shop_item_table.sv
// Item database (name/owner/stock) executing ADD/DEL/BUY/QUERY with a fixed-length linear scan.
// Latency: o_done pulses in the cycle after edge accept+MAX_ITEMS+1; one request per MAX_ITEMS+2 cycles.
// Backpressure: o_ready is high only in IDLE; requests are accepted on i_valid & o_ready.
module shop_item_table #(
    parameter int NAME_CHARS = 7,
    parameter int NAME_BITS  = NAME_CHARS * 8,
    parameter int STOCK_BITS = 8,
    parameter int MAX_ITEMS  = 8,
    parameter int USER_BITS  = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    shop_item_table_if.slave   bus
);
    localparam int IDX_W = $clog2(MAX_ITEMS);
    localparam int CNT_W = $clog2(MAX_ITEMS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_ITEMS - 1);

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_DEL   = 2'b01;
    localparam logic [1:0] OP_BUY   = 2'b10;
    localparam logic [1:0] OP_QUERY = 2'b11;

    localparam logic [2:0] ST_OK        = 3'd0;
    localparam logic [2:0] ST_FULL      = 3'd1;
    localparam logic [2:0] ST_EXISTS    = 3'd2;
    localparam logic [2:0] ST_UNKNOWN   = 3'd3;
    localparam logic [2:0] ST_NOT_OWNER = 3'd4;
    localparam logic [2:0] ST_NO_STOCK  = 3'd5;
    localparam logic [2:0] ST_BAD_QTY   = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EXEC} state_t;

    state_t state, state_n;

    // table storage; only the valid bits need reset
    logic [MAX_ITEMS-1:0]  slot_vld;
    logic [NAME_BITS-1:0]  slot_name  [MAX_ITEMS];
    logic [USER_BITS-1:0]  slot_owner [MAX_ITEMS];
    logic [STOCK_BITS-1:0] slot_stock [MAX_ITEMS];

    // latched request
    logic [1:0]            req_op;
    logic [USER_BITS-1:0]  req_user;
    logic                  req_admin;
    logic [NAME_BITS-1:0]  req_name;
    logic [STOCK_BITS-1:0] req_qty;

    // scan results
    logic [IDX_W-1:0]      idx;
    logic                  have_match;
    logic [IDX_W-1:0]      match_idx;
    logic                  have_free;
    logic [IDX_W-1:0]      free_idx;

    // registered outputs
    logic                  done_q;
    logic [2:0]            status_q;
    logic [STOCK_BITS-1:0] stock_q;
    logic [CNT_W-1:0]      count_q;

    // execution decision
    logic [2:0]            exec_status;
    logic [STOCK_BITS-1:0] exec_stock;
    logic                  do_add;
    logic                  do_del;
    logic                  do_buy;
    logic [STOCK_BITS-1:0] match_stock;

    logic accept;
    logic exec;

    assign accept      = bus.i_valid && (state == S_IDLE);
    assign exec        = (state == S_EXEC);
    assign match_stock = slot_stock[match_idx];

    assign bus.o_ready  = (state == S_IDLE);
    assign bus.o_done   = done_q;
    assign bus.o_status = status_q;
    assign bus.o_stock  = stock_q;
    assign bus.o_count  = count_q;

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FSM next state: scan always visits every slot so latency is fixed
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (bus.i_valid) state_n = S_SCAN;
            S_SCAN:  if (idx == LAST_IDX) state_n = S_EXEC;
            S_EXEC:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // request latch and slot scan (lowest free slot, unique name match)
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            req_op     <= '0;
            req_user   <= '0;
            req_admin  <= 1'b0;
            req_name   <= '0;
            req_qty    <= '0;
            idx        <= '0;
            have_match <= 1'b0;
            match_idx  <= '0;
            have_free  <= 1'b0;
            free_idx   <= '0;
        end else if (accept) begin
            req_op     <= bus.i_op;
            req_user   <= bus.i_user;
            req_admin  <= bus.i_is_admin;
            req_name   <= bus.i_name;
            req_qty    <= bus.i_qty;
            idx        <= '0;
            have_match <= 1'b0;
            have_free  <= 1'b0;
        end else if (state == S_SCAN) begin
            if (slot_vld[idx] && (slot_name[idx] == req_name)) begin
                have_match <= 1'b1;
                match_idx  <= idx;
            end
            if (!slot_vld[idx] && !have_free) begin
                have_free <= 1'b1;
                free_idx  <= idx;
            end
            idx <= idx + 1'b1;
        end
    end

    // operation outcome, evaluated while in EXEC
    always_comb begin
        exec_status = ST_OK;
        exec_stock  = '0;
        do_add      = 1'b0;
        do_del      = 1'b0;
        do_buy      = 1'b0;
        case (req_op)
            OP_ADD: begin
                if (have_match) begin
                    exec_status = ST_EXISTS;
                end else if (!have_free) begin
                    exec_status = ST_FULL;
                end else begin
                    exec_stock = req_qty;
                    do_add     = 1'b1;
                end
            end
            OP_DEL: begin
                if (!have_match) begin
                    exec_status = ST_UNKNOWN;
                end else if ((slot_owner[match_idx] != req_user) && !req_admin) begin
                    exec_status = ST_NOT_OWNER;
                end else begin
                    do_del = 1'b1;
                end
            end
            OP_BUY: begin
                if (req_qty == '0) begin
                    exec_status = ST_BAD_QTY;
                end else if (!have_match) begin
                    exec_status = ST_UNKNOWN;
                end else if (match_stock < req_qty) begin
                    exec_status = ST_NO_STOCK;
                end else begin
                    exec_stock = match_stock - req_qty;
                    do_buy     = 1'b1;
                end
            end
            OP_QUERY: begin
                if (!have_match) begin
                    exec_status = ST_UNKNOWN;
                end else begin
                    exec_stock = match_stock;
                end
            end
            default: exec_status = ST_UNKNOWN;
        endcase
    end

    // slot valid bits: set on successful ADD, cleared on successful DEL
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            slot_vld <= '0;
        end else if (exec) begin
            if (do_add) slot_vld[free_idx]  <= 1'b1;
            if (do_del) slot_vld[match_idx] <= 1'b0;
        end
    end

    // slot payload: written on ADD, stock reduced on BUY
    always_ff @(posedge i_clk) begin
        if (exec && do_add) begin
            slot_name[free_idx]  <= req_name;
            slot_owner[free_idx] <= req_user;
            slot_stock[free_idx] <= req_qty;
        end
        if (exec && do_buy) begin
            slot_stock[match_idx] <= exec_stock;
        end
    end

    // result registers: status/stock hold until the next EXEC
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            done_q   <= 1'b0;
            status_q <= '0;
            stock_q  <= '0;
            count_q  <= '0;
        end else begin
            done_q <= exec;
            if (exec) begin
                status_q <= exec_status;
                stock_q  <= exec_stock;
                if (do_add) count_q <= count_q + 1'b1;
                if (do_del) count_q <= count_q - 1'b1;
            end
        end
    end
endmodule
